mem_byte_ctrl: RTL and testbench

Load/store sequencer that sits directly upstream of the memory stage: it accepts one load or store request at a time from the execute stage and drives the memory stage's write-enable, address and write-data ports, consuming its read data. Byte stores are turned into read-modify-write sequences over the word-wide synchronous RAM. Loads return an extracted byte or a full word. A ready/valid handshake stalls the pipeline while a sequence is in flight.

---
 rtl/mem_ctrl_pkg.sv | 16 +
 rtl/byte_lane_merge.sv | 28 ++
 rtl/mem_byte_ctrl.sv | 116 +++++++++++
 tb/tb_mem_byte_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the load/store byte sequencer: FSM states, byte lane width and the
// address bits the word-wide RAM decodes.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StCap,
    StWr
  } state_e;

  localparam int unsigned LaneW    = 8;
  localparam int unsigned RamIdxHi = 11;
  localparam int unsigned RamIdxLo = 2;

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte lane helper: inserts a byte into one little-endian lane of a word, and
// extracts one lane as a 32-bit load result.
// Build option: MEM_LB_SIGNEXT_EN selects sign extension of the extracted byte (default: zero).
module byte_lane_merge
  import mem_ctrl_pkg::*;
(
  input  logic [31:0]      word_i,
  input  logic [1:0]       lane_i,
  input  logic [LaneW-1:0] byte_i,
  output logic [31:0]      merged_o,
  output logic [31:0]      extracted_o
);

  logic [LaneW-1:0] lane_byte;

  // Replace the selected lane and pick the same lane out for loads.
  always_comb begin
    merged_o                        = word_i;
    merged_o[LaneW*lane_i +: LaneW] = byte_i;
    lane_byte                       = word_i[LaneW*lane_i +: LaneW];
`ifdef MEM_LB_SIGNEXT_EN
    extracted_o = {{(32 - LaneW){lane_byte[LaneW-1]}}, lane_byte};
`else
    extracted_o = {{(32 - LaneW){1'b0}}, lane_byte};
`endif
  end

endmodule

// File: rtl/mem_byte_ctrl.sv
// Load/store sequencer in front of the memory stage. Accepts one request at a time, turns byte
// stores into read-modify-write over the word RAM, and returns byte or word load data.
// Build option: MEM_LB_SIGNEXT_EN makes byte loads sign-extend (handled in byte_lane_merge).
module mem_byte_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              Mem_WrEn,
  output logic [ADDR_W-1:0] ALU_MEM_Addr,
  output logic [DATA_W-1:0] MEM_DataIn,
  input  logic [DATA_W-1:0] MEM_DataOut
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic              byte_q, byte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  // Holds the store word on acceptance, then the merged word for byte stores.
  logic [DATA_W-1:0] data_q, data_d;

  logic [31:0] merged_word;
  logic [31:0] load_byte;
  logic        misaligned;

  byte_lane_merge u_merge (
    .word_i      (MEM_DataOut),
    .lane_i      (addr_q[1:0]),
    .byte_i      (data_q[LaneW-1:0]),
    .merged_o    (merged_word),
    .extracted_o (load_byte)
  );

  // Next-state logic for the FSM and the request latch.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          byte_d  = req_byte;
          addr_d  = req_addr;
          data_d  = req_wdata;
          state_d = (req_we && !req_byte) ? StWr : StRd;
        end
      end
      StRd: state_d = StCap;
      StCap: begin
        if (we_q) begin
          data_d  = merged_word;
          state_d = StWr;
        end else begin
          state_d = StIdle;
        end
      end
      StWr:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and request registers; reset aborts any sequence without writing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Memory-side outputs decode registered state only, so the write enable cannot glitch.
  assign req_ready    = (state_q == StIdle);
  assign Mem_WrEn     = (state_q == StWr);
  assign ALU_MEM_Addr = addr_q;
  assign MEM_DataIn   = data_q;
  assign misaligned   = !byte_q && (addr_q[1:0] != 2'b00);

  // Completion pulse: load data is returned in the capture cycle, stores complete on the write.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    if (state_q == StCap && !we_q) begin
      rsp_valid = 1'b1;
      rsp_rdata = byte_q ? load_byte : MEM_DataOut;
      rsp_err   = misaligned;
    end else if (state_q == StWr) begin
      rsp_valid = 1'b1;
      rsp_err   = misaligned;
    end
  end

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Self-checking bench for mem_byte_ctrl with a synchronous word RAM model standing in for the
// memory stage. Expected responses and writes are queued at request time and checked as the DUT
// produces them.
module tb_mem_byte_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_byte;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        Mem_WrEn;
  logic [31:0] ALU_MEM_Addr;
  logic [31:0] MEM_DataIn;
  logic [31:0] MEM_DataOut;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  rsp_t        rsp_q[$];
  wr_t         wr_q[$];
  logic [31:0] ram   [0:1023];
  logic [31:0] model [0:1023];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          acc_cnt     = 0;

  always #5 clk = ~clk;

  mem_byte_ctrl #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_byte     (req_byte),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .Mem_WrEn     (Mem_WrEn),
    .ALU_MEM_Addr (ALU_MEM_Addr),
    .MEM_DataIn   (MEM_DataIn),
    .MEM_DataOut  (MEM_DataOut)
  );

  // Memory stage: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (Mem_WrEn) ram[ALU_MEM_Addr[RamIdxHi:RamIdxLo]] <= MEM_DataIn;
    MEM_DataOut <= ram[ALU_MEM_Addr[RamIdxHi:RamIdxLo]];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (req_valid === 1'b1 && req_ready === 1'b1) acc_cnt <= acc_cnt + 1;

  // Response scoreboard.
  always @(negedge clk) begin : mon_rsp
    rsp_t e;
    if (rsp_valid === 1'b1) begin
      vectors++;
      if (rsp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        e = rsp_q.pop_front();
        if (rsp_rdata !== e.rdata || rsp_err !== e.err || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL rsp: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                   rsp_rdata, rsp_err, cyc, e.rdata, e.err, e.cyc);
        end
      end
    end else if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_rsp: got valid=%b rdata=%h err=%b, required 0/0/0", rsp_valid,
               rsp_rdata, rsp_err);
    end
  end

  // Write scoreboard.
  always @(negedge clk) begin : mon_wr
    wr_t e;
    if (Mem_WrEn !== 1'b0) begin
      vectors++;
      if (wr_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_wr: Mem_WrEn=%b at cycle %0d addr=%h data=%h, required 0",
                 Mem_WrEn, cyc, ALU_MEM_Addr, MEM_DataIn);
      end else begin
        e = wr_q.pop_front();
        if (ALU_MEM_Addr !== e.addr || MEM_DataIn !== e.data || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL wr: got addr=%h data=%h cycle=%0d, required addr=%h data=%h cycle=%0d",
                   ALU_MEM_Addr, MEM_DataIn, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  // Queue the expected outcome of a request accepted at the edge after cycle count a.
  task automatic expect_req(input logic we, input logic by, input logic [31:0] addr,
                            input logic [31:0] wdata, input int a);
    int          idx;
    int          lane;
    logic [31:0] w;
    logic [7:0]  b;
    logic        err;
    idx  = int'(addr[11:2]);
    lane = int'(addr[1:0]);
    w    = model[idx];
    err  = !by && (addr[1:0] != 2'b00);
    if (we && !by) begin
      model[idx] = wdata;
      wr_q.push_back('{addr: addr, data: wdata, cyc: a + 1});
      rsp_q.push_back('{rdata: 32'h0, err: err, cyc: a + 1});
    end else if (we) begin
      w[8*lane +: 8] = wdata[7:0];
      model[idx]     = w;
      wr_q.push_back('{addr: addr, data: w, cyc: a + 3});
      rsp_q.push_back('{rdata: 32'h0, err: 1'b0, cyc: a + 3});
    end else if (by) begin
      b = w[8*lane +: 8];
`ifdef MEM_LB_SIGNEXT_EN
      rsp_q.push_back('{rdata: {{24{b[7]}}, b}, err: 1'b0, cyc: a + 2});
`else
      rsp_q.push_back('{rdata: {24'h0, b}, err: 1'b0, cyc: a + 2});
`endif
    end else begin
      rsp_q.push_back('{rdata: w, err: err, cyc: a + 2});
    end
  endtask

  // Present a request, wait for acceptance, then drop req_valid.
  task automatic issue(input logic we, input logic by, input logic [31:0] addr,
                       input logic [31:0] wdata, output int a);
    int k;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_byte  = by;
    req_addr  = addr;
    req_wdata = wdata;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    a = cyc;
    if (k == 20) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: req_ready=%b, required 1 within 20 cycles", req_ready);
    end else begin
      expect_req(we, by, addr, wdata, a);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (rsp_q.size() != 0 || wr_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: %0d rsp and %0d wr pending, required 0", rsp_q.size(),
               wr_q.size());
      rsp_q.delete();
      wr_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
        Mem_WrEn !== 1'b0 || ALU_MEM_Addr !== 32'h0 || MEM_DataIn !== 32'h0) begin
      miscompares++;
      $display("FAIL reset: got rdy=%b v=%b rd=%h err=%b we=%b a=%h d=%h, required 1/0/0/0/0/0/0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, Mem_WrEn, ALU_MEM_Addr, MEM_DataIn);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_store();
    int a;
    issue(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, a);
    wait_done();
    vectors++;
    if (ALU_MEM_Addr !== 32'h10) begin
      miscompares++;
      $display("FAIL addr_hold: got %h, required 00000010", ALU_MEM_Addr);
    end
  endtask

  task automatic test_byte_store();
    int a;
    issue(1'b1, 1'b0, 32'h20, 32'h11223344, a);
    wait_done();
    issue(1'b1, 1'b1, 32'h22, 32'hFFFFFFAA, a);
    wait_done();
    vectors++;
    if (ram[8] !== 32'h11AA3344) begin
      miscompares++;
      $display("FAIL byte_merge: got %h, required 11aa3344", ram[8]);
    end
  endtask

  task automatic test_byte_load();
    int a;
    issue(1'b1, 1'b0, 32'h30, 32'h80FF7F01, a);
    wait_done();
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b1, 32'h30 + 32'(i), 32'h0, a);
      wait_done();
    end
  endtask

  task automatic test_word_load_misaligned();
    int a;
    int c0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_byte  = 1'b0;
    req_addr  = 32'h21;
    req_wdata = 32'h0;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_ready: got req_ready=%b before acceptance, required 1", req_ready);
    end
    a  = cyc;
    c0 = acc_cnt;
    expect_req(1'b0, 1'b0, 32'h21, 32'h0, a);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_ready: got req_ready=%b in busy cycle %0d, required 0", req_ready, i);
      end
    end
    req_valid = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    vectors++;
    if (acc_cnt - c0 != 1) begin
      miscompares++;
      $display("FAIL hold_accept: got %0d acceptances, required 1", acc_cnt - c0);
    end
    issue(1'b1, 1'b0, 32'h13, 32'hCAFEF00D, a);
    wait_done();
  endtask

  task automatic test_reset_abort();
    int a;
    issue(1'b1, 1'b0, 32'h40, 32'h55667788, a);
    wait_done();
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_byte  = 1'b1;
    req_addr  = 32'h41;
    req_wdata = 32'h99;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (Mem_WrEn !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: got we=%b rdy=%b v=%b, required 0/1/0", Mem_WrEn, req_ready,
               rsp_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (ram[16] !== 32'h55667788) begin
      miscompares++;
      $display("FAIL abort_ram: got %h, required 55667788", ram[16]);
    end
    issue(1'b0, 1'b0, 32'h40, 32'h0, a);
    wait_done();
  endtask

  task automatic test_back_to_back();
    int a1;
    int a2;
    issue(1'b1, 1'b1, 32'h43, 32'h0000005A, a1);
    issue(1'b0, 1'b0, 32'h40, 32'h0, a2);
    wait_done();
    vectors++;
    if (a2 - a1 != 4) begin
      miscompares++;
      $display("FAIL b2b_spacing: got %0d cycles between acceptances, required 4", a2 - a1);
    end
    vectors++;
    if (ALU_MEM_Addr !== 32'h40 || ram[16] !== 32'h5A667788) begin
      miscompares++;
      $display("FAIL b2b_state: got addr=%h word=%h, required 00000040 5a667788", ALU_MEM_Addr,
               ram[16]);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_byte  = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;
    test_reset();
    test_word_store();
    test_byte_store();
    test_byte_load();
    test_word_load_misaligned();
    test_reset_abort();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
